// File: rtl/systola_pkg.sv
// Shared constants, drain FSM state type and the lane-value reduction for the systolic array.
// Define LIN_DRAIN_SAT_EN to saturate; leave it undefined to truncate.
package systola_pkg;

  localparam int N_PE  = 4;
  localparam int ACC_W = 12;
  localparam int OUT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  // Width-generic so callers with non-default ACC_W/OUT_W can share it; caller keeps the low out_w bits.
  function automatic logic [63:0] reduce_acc(input logic [63:0] acc, input int out_w);
    logic [63:0] max_v;
    max_v = (64'd1 << out_w) - 64'd1;
`ifdef LIN_DRAIN_SAT_EN
    return (acc > max_v) ? max_v : acc;
`else
    return acc & max_v;
`endif
  endfunction

endpackage

// File: rtl/lin_drain_bank.sv
// One snapshot bank: N_PE accumulator values plus an occupancy bit, with a single lane read port.
module lin_drain_bank
  import systola_pkg::*;
#(
  parameter int N_PE   = systola_pkg::N_PE,
  parameter int ACC_W  = systola_pkg::ACC_W,
  parameter int LANE_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [N_PE*ACC_W-1:0] data_i,
  input  logic [LANE_W-1:0]     rd_lane_i,
  output logic                  valid_o,
  output logic [ACC_W-1:0]      rd_data_o
);

  logic [ACC_W-1:0] mem_q [N_PE];
  logic             valid_q;

  // Data storage carries no reset; only the occupancy bit is control.
  always_ff @(posedge clk) begin
    if (load_i) begin
      for (int i = 0; i < N_PE; i++) begin
        mem_q[i] <= data_i[i*ACC_W +: ACC_W];
      end
    end
  end

  // Load wins over clear so a refill on the freeing edge keeps the bank occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o   = valid_q;
  assign rd_data_o = mem_q[rd_lane_i];

endmodule

// File: rtl/lin_drain.sv
// Drain stage: snapshots PE outputs on the fire falling edge and streams them one lane per beat.
// Reduction selected by LIN_DRAIN_SAT_EN (saturate) versus default truncation.
module lin_drain
  import systola_pkg::*;
#(
  parameter int N_PE   = systola_pkg::N_PE,
  parameter int ACC_W  = systola_pkg::ACC_W,
  parameter int OUT_W  = systola_pkg::OUT_W,
  localparam int LANE_W = (N_PE > 1) ? $clog2(N_PE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fire,
  input  logic [N_PE*ACC_W-1:0] pe_outs,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_W-1:0]      m_data,
  output logic [LANE_W-1:0]     m_lane,
  output logic                  m_last,
  output logic                  busy,
  output logic                  overflow
);

  drain_state_t      state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              act_sel_q, act_sel_d;
  logic              fire_q;
  logic              overflow_q, overflow_d;

  logic [1:0]        bank_vld, bank_load, bank_clr;
  logic [ACC_W-1:0]  bank_rd [2];
  logic [ACC_W-1:0]  act_rd;
  logic [63:0]       red_full;
  logic [63-OUT_W:0] unused_red_bits;

  logic xfer, last_xfer, cap, act_v, pend_v, promote, sel_after, act_empty, pend_empty;

  lin_drain_bank #(.N_PE(N_PE), .ACC_W(ACC_W), .LANE_W(LANE_W)) u_bank0 (
    .clk(clk), .rst(rst), .load_i(bank_load[0]), .clear_i(bank_clr[0]), .data_i(pe_outs),
    .rd_lane_i(lane_q), .valid_o(bank_vld[0]), .rd_data_o(bank_rd[0])
  );

  lin_drain_bank #(.N_PE(N_PE), .ACC_W(ACC_W), .LANE_W(LANE_W)) u_bank1 (
    .clk(clk), .rst(rst), .load_i(bank_load[1]), .clear_i(bank_clr[1]), .data_i(pe_outs),
    .rd_lane_i(lane_q), .valid_o(bank_vld[1]), .rd_data_o(bank_rd[1])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      act_sel_q  <= 1'b0;
      fire_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      act_sel_q  <= act_sel_d;
      fire_q     <= fire;
      overflow_q <= overflow_d;
    end
  end

  // ACTIVE/PENDING are roles swapped by act_sel_q, so promotion is a pointer flip, not a copy.
  always_comb begin
    bank_load  = 2'b00;
    bank_clr   = 2'b00;
    overflow_d = overflow_q;
    m_valid    = (state_q == DRAIN);
    xfer       = m_valid & m_ready;
    last_xfer  = xfer & (lane_q == LANE_W'(N_PE - 1));
    cap        = fire_q & ~fire;
    act_v      = act_sel_q ? bank_vld[1] : bank_vld[0];
    pend_v     = act_sel_q ? bank_vld[0] : bank_vld[1];
    promote    = last_xfer & pend_v;
    sel_after  = act_sel_q ^ promote;
    act_empty  = last_xfer ? ~pend_v : ~act_v;
    pend_empty = last_xfer | ~pend_v;

    if (last_xfer) begin
      bank_clr[act_sel_q] = 1'b1;
    end
    // Routing uses post-handshake occupancy so a capture on the last beat lands without a bubble.
    if (cap) begin
      if (act_empty) begin
        bank_load[sel_after] = 1'b1;
      end else if (pend_empty) begin
        bank_load[~sel_after] = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    act_sel_d = sel_after;
    state_d   = (~act_empty | cap) ? DRAIN : IDLE;
    if (last_xfer) begin
      lane_d = '0;
    end else if (xfer) begin
      lane_d = lane_q + LANE_W'(1);
    end else begin
      lane_d = lane_q;
    end
  end

  always_comb begin
    act_rd          = act_sel_q ? bank_rd[1] : bank_rd[0];
    red_full        = reduce_acc(64'(act_rd), OUT_W);
    unused_red_bits = red_full[63:OUT_W];
    m_data          = m_valid ? red_full[OUT_W-1:0] : '0;
  end

  assign m_lane   = lane_q;
  assign m_last   = m_valid & (lane_q == LANE_W'(N_PE - 1));
  assign busy     = bank_vld[0] | bank_vld[1];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_lin_drain.sv
// Randomised and directed bench for lin_drain: snapshot-queue reference model feeding a beat scoreboard.
module tb_lin_drain;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int OW = 8;
  localparam int LW = 2;
`ifdef LIN_DRAIN_SAT_EN
  localparam int EXP300 = 255;
`else
  localparam int EXP300 = 44;
`endif

  logic          clk = 1'b0;
  logic          rst, fire, m_ready;
  logic [N*AW-1:0] pe_outs;
  logic          m_valid, m_last, busy, overflow;
  logic [OW-1:0] m_data;
  logic [LW-1:0] m_lane;

  lin_drain dut (
    .clk(clk), .rst(rst), .fire(fire), .pe_outs(pe_outs), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_lane(m_lane), .m_last(m_last), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_reduce(input int v);
    int mx;
    mx = (1 << OW) - 1;
`ifdef LIN_DRAIN_SAT_EN
    return (v > mx) ? mx : v;
`else
    return v % (mx + 1);
`endif
  endfunction

  typedef struct {
    int data;
    int lane;
    bit last;
  } beat_t;

  beat_t sb[$];

  // Reference: count of stored snapshots (at most two) and position within the oldest one.
  int outstanding = 0;
  int beat_idx    = 0;
  bit m_ovf       = 1'b0;
  bit prev_fire   = 1'b0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      outstanding = 0;
      beat_idx    = 0;
      m_ovf       = 1'b0;
      prev_fire   = 1'b0;
      sb.delete();
    end else begin
      check("m_valid", m_valid, outstanding > 0);
      check("busy", busy, outstanding > 0);
      check("overflow", overflow, m_ovf);
      if (outstanding > 0 && m_ready) begin
        beat_idx++;
        if (beat_idx == N) begin
          beat_idx = 0;
          outstanding--;
        end
      end
      if (prev_fire && !fire) begin
        if (outstanding < 2) begin
          outstanding++;
          for (int i = 0; i < N; i++) begin
            beat_t b;
            b.data = ref_reduce(int'(pe_outs[i*AW +: AW]));
            b.lane = i;
            b.last = (i == N - 1);
            sb.push_back(b);
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
      prev_fire = fire;
    end
  end

  // Monitor: pops the scoreboard on each accepted beat and checks hold-stability under stall.
  bit            stalled = 1'b0;
  logic [OW-1:0] held_data;
  logic [LW-1:0] held_lane;

  always @(negedge clk) begin
    if (rst !== 1'b1 && m_valid === 1'b1) begin
      if (stalled) begin
        check("stall_data", m_data, held_data);
        check("stall_lane", m_lane, held_lane);
      end
      if (m_ready) begin
        stalled = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("m_data", m_data, e.data);
          check("m_lane", m_lane, e.lane);
          check("m_last", m_last, e.last);
        end
      end else begin
        stalled   = 1'b1;
        held_data = m_data;
        held_lane = m_lane;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pe(input int v0, input int v1, input int v2, input int v3);
    pe_outs = {AW'(v3), AW'(v2), AW'(v1), AW'(v0)};
  endtask

  task automatic capture(input int hi_cycles);
    fire = 1'b1;
    repeat (hi_cycles) tick();
    fire = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; fire = 1'b0; m_ready = 1'b0; pe_outs = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_lane", m_lane, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    tick();

    // Basic drain: w=0..3 accumulated over a=1..8 gives w*36.
    m_ready = 1'b1;
    set_pe(0, 36, 72, 108);
    capture(8);
    repeat (8) tick();

    // Backpressure pattern 1,0,0,1,...
    capture(8);
    for (int i = 0; i < 20; i++) begin
      m_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    m_ready = 1'b1;
    repeat (4) tick();

    // Back-to-back: second pass lands in the pending bank.
    m_ready = 1'b0;
    set_pe(1, 2, 3, 4);
    capture(2);
    set_pe(500, 600, 700, 800);
    capture(2);
    m_ready = 1'b1;
    repeat (10) tick();

    // Overflow: third capture dropped.
    m_ready = 1'b0;
    set_pe(10, 11, 12, 13);
    capture(1);
    set_pe(20, 21, 22, 23);
    capture(1);
    set_pe(30, 31, 32, 33);
    capture(1);
    check("overflow_set", overflow, 1);
    m_ready = 1'b1;
    repeat (12) tick();

    // Reduction of an out-of-range lane value.
    set_pe(300, 1, 2, 4095);
    capture(1);
    check("reduce_300", m_data, EXP300);
    repeat (6) tick();

    // Reset right after lane 1 transfers, with fire held high across reset.
    set_pe(7, 8, 9, 10);
    capture(1);
    tick();
    tick();
    rst  = 1'b1;
    fire = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_valid", m_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_overflow", overflow, 0);
    repeat (4) tick();
    check("no_beat_fire_high", m_valid, 0);
    fire = 1'b0;
    tick();
    repeat (6) tick();

    // Randomised traffic, with occasional reset.
    for (int i = 0; i < 1500; i++) begin
      fire    = ($urandom_range(0, 3) != 0) ? fire : ~fire;
      m_ready = ($urandom_range(0, 9) < 7);
      pe_outs = {AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom)};
      rst     = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; fire = 1'b0; m_ready = 1'b1;
    repeat (12) tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
